lcd_spi_rx: RTL and testbench

Receive-side model of the 4-wire SPI LCD link (cs, rs/dc, clk, data), i.e. the panel end of the link our LCD driver transmits on.
- Deserialises bytes and decodes ST7789-style commands (CASET/RASET/RAMWR, sleep/display on-off).
- Emits addressed RGB565 pixel writes.
- Used as an on-chip loopback/capture target and as a panel stand-in for framebuffer checking.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_spi_deser.sv | 49 ++++
 rtl/lcd_spi_rx.sv | 185 ++++++++++++++++++
 tb/tb_lcd_spi_rx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the SPI LCD receive model.
//   - ST7789-style command opcodes recognised by the decoder
//   - decoder state encoding
//   - default window end coordinates applied at reset / SWRESET
package lcd_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  localparam int DEF_XE = 239;
  localparam int DEF_YE = 319;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_RASET,
    ST_RAMWR,
    ST_SKIP
  } dec_state_t;

endpackage

// File: rtl/lcd_spi_deser.sv
// lcd_spi_deser: bit-level front end of the SPI LCD receiver.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   lcd_cs          chip select, active low
//   lcd_rs          command(0)/data(1) select
//   lcd_data        serial data, MSB first
//   byte_valid      high while the current edge will sample the 8th bit
//   rx_byte         the byte completed on that edge
//   dc              lcd_rs as seen on that edge
//   framing_error   high while the current edge sees cs released mid-byte
// All four outputs describe what happens on the upcoming clk edge, so the
// decoder can register its strobes on that same edge and keep the overall
// latency at one cycle after the final bit.
module lcd_spi_deser (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_cs,
  input  logic       lcd_rs,
  input  logic       lcd_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       dc,
  output logic       framing_error
);

  logic [2:0] bit_cnt;
  // Only the first seven bits need storing; the eighth is the live input.
  logic [6:0] shift_reg;

  assign byte_valid    = !lcd_cs && (bit_cnt == 3'd7);
  assign rx_byte       = {shift_reg, lcd_data};
  assign dc            = lcd_rs;
  assign framing_error = lcd_cs && (bit_cnt != 3'd0);

  // Counter wraps from 7 to 0, so back-to-back bytes under one cs-low run
  // are framed without any gap. Releasing cs drops any partial byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 3'd0;
      shift_reg <= 7'd0;
    end else if (!lcd_cs) begin
      shift_reg <= {shift_reg[5:0], lcd_data};
      bit_cnt   <= bit_cnt + 3'd1;
    end else begin
      bit_cnt <= 3'd0;
    end
  end

endmodule

// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: panel-side model of the 4-wire SPI LCD link.
// Decodes ST7789-style commands and turns RAMWR data into addressed
// RGB565 pixel writes within the CASET/RASET window.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   lcd_resetn        panel reset (active low, synchronous), same as rst
//   lcd_cs/rs/data    SPI link: chip select, command/data, serial data
//   cmd_valid/byte    one-cycle strobe and value of each command byte
//   pixel_valid/x/y/data  one-cycle strobe for each written pixel
//   frame_done        pulses with the pixel that completes the window
//   sleep_out         level, set by SLPOUT, cleared by SLPIN/SWRESET
//   display_on        level, set by DISPON, cleared by DISPOFF/SWRESET
//   framing_error     one-cycle strobe, cs released mid-byte
module lcd_spi_rx #(
  parameter int COORD_W = 9,
  parameter int DEF_XE  = lcd_pkg::DEF_XE,
  parameter int DEF_YE  = lcd_pkg::DEF_YE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lcd_resetn,
  input  logic               lcd_cs,
  input  logic               lcd_rs,
  input  logic               lcd_data,
  output logic               cmd_valid,
  output logic [7:0]         cmd_byte,
  output logic               pixel_valid,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic [15:0]        pixel_data,
  output logic               frame_done,
  output logic               sleep_out,
  output logic               display_on,
  output logic               framing_error
);
  import lcd_pkg::*;

  localparam logic [COORD_W-1:0] XE_RST = COORD_W'(DEF_XE);
  localparam logic [COORD_W-1:0] YE_RST = COORD_W'(DEF_YE);

  logic       any_rst;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       dc;
  logic       frame_err;

  assign any_rst = rst || !lcd_resetn;

  lcd_spi_deser u_deser (
    .clk           (clk),
    .rst           (any_rst),
    .lcd_cs        (lcd_cs),
    .lcd_rs        (lcd_rs),
    .lcd_data      (lcd_data),
    .byte_valid    (byte_valid),
    .rx_byte       (rx_byte),
    .dc            (dc),
    .framing_error (frame_err)
  );

  dec_state_t         state;
  logic [2:0]         param_idx;
  logic [7:0]         p0, p1, p2;
  logic [7:0]         hi_byte;
  logic               phase_lo;
  logic [COORD_W-1:0] xs, xe, ys, ye;
  logic [COORD_W-1:0] cur_x, cur_y;

  // Using >= rather than == keeps the cursor inside the legal range even
  // when the window is inverted (start > end): it simply wraps each pixel.
  logic x_wrap, y_wrap;
  assign x_wrap = cur_x >= xe;
  assign y_wrap = cur_y >= ye;

  always_ff @(posedge clk) begin
    if (any_rst) begin
      state         <= ST_IDLE;
      param_idx     <= 3'd0;
      p0            <= 8'd0;
      p1            <= 8'd0;
      p2            <= 8'd0;
      hi_byte       <= 8'd0;
      phase_lo      <= 1'b0;
      xs            <= '0;
      xe            <= XE_RST;
      ys            <= '0;
      ye            <= YE_RST;
      cur_x         <= '0;
      cur_y         <= '0;
      cmd_valid     <= 1'b0;
      cmd_byte      <= 8'd0;
      pixel_valid   <= 1'b0;
      pixel_x       <= '0;
      pixel_y       <= '0;
      pixel_data    <= 16'd0;
      frame_done    <= 1'b0;
      sleep_out     <= 1'b0;
      display_on    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      cmd_valid     <= 1'b0;
      pixel_valid   <= 1'b0;
      frame_done    <= 1'b0;
      framing_error <= frame_err;
      if (byte_valid && !dc) begin
        // Every command aborts whatever parameter/pixel transfer was open.
        cmd_valid <= 1'b1;
        cmd_byte  <= rx_byte;
        param_idx <= 3'd0;
        phase_lo  <= 1'b0;
        state     <= ST_IDLE;
        case (rx_byte)
          CMD_CASET: state <= ST_CASET;
          CMD_RASET: state <= ST_RASET;
          CMD_RAMWR: begin
            state <= ST_RAMWR;
            cur_x <= xs;
            cur_y <= ys;
          end
          CMD_SLPOUT:  sleep_out  <= 1'b1;
          CMD_SLPIN:   sleep_out  <= 1'b0;
          CMD_DISPON:  display_on <= 1'b1;
          CMD_DISPOFF: display_on <= 1'b0;
          CMD_SWRESET: begin
            xs         <= '0;
            xe         <= XE_RST;
            ys         <= '0;
            ye         <= YE_RST;
            sleep_out  <= 1'b0;
            display_on <= 1'b0;
          end
          default: state <= ST_SKIP;
        endcase
      end else if (byte_valid) begin
        case (state)
          ST_CASET, ST_RASET: begin
            // Start and end are only committed once all four parameters
            // arrived, so a short parameter list leaves the window intact.
            case (param_idx)
              3'd0: p0 <= rx_byte;
              3'd1: p1 <= rx_byte;
              3'd2: p2 <= rx_byte;
              3'd3: begin
                if (state == ST_CASET) begin
                  xs <= COORD_W'({p0, p1});
                  xe <= COORD_W'({p2, rx_byte});
                end else begin
                  ys <= COORD_W'({p0, p1});
                  ye <= COORD_W'({p2, rx_byte});
                end
              end
              default: ;
            endcase
            if (param_idx != 3'd4) param_idx <= param_idx + 3'd1;
          end
          ST_RAMWR: begin
            if (!phase_lo) begin
              hi_byte  <= rx_byte;
              phase_lo <= 1'b1;
            end else begin
              pixel_valid <= 1'b1;
              pixel_data  <= {hi_byte, rx_byte};
              pixel_x     <= cur_x;
              pixel_y     <= cur_y;
              phase_lo    <= 1'b0;
              if (x_wrap) begin
                cur_x <= xs;
                if (y_wrap) begin
                  cur_y      <= ys;
                  frame_done <= 1'b1;
                end else begin
                  cur_y <= cur_y + COORD_W'(1);
                end
              end else begin
                cur_x <= cur_x + COORD_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_spi_rx.sv
// tb_lcd_spi_rx: self-checking bench for lcd_spi_rx.
// Drives SPI bytes, compares every strobe and level against a byte-level
// reference model of the panel protocol, then runs randomized traffic.
module tb_lcd_spi_rx;

  localparam int COORD_W = 9;
  localparam int M_IDLE  = 0;
  localparam int M_CASET = 1;
  localparam int M_RASET = 2;
  localparam int M_RAMWR = 3;
  localparam int M_SKIP  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               lcd_resetn;
  logic               lcd_cs;
  logic               lcd_rs;
  logic               lcd_data;
  logic               cmd_valid;
  logic [7:0]         cmd_byte;
  logic               pixel_valid;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic [15:0]        pixel_data;
  logic               frame_done;
  logic               sleep_out;
  logic               display_on;
  logic               framing_error;

  always #5 clk = ~clk;

  lcd_spi_rx #(.COORD_W(COORD_W), .DEF_XE(239), .DEF_YE(319)) dut (
    .clk           (clk),
    .rst           (rst),
    .lcd_resetn    (lcd_resetn),
    .lcd_cs        (lcd_cs),
    .lcd_rs        (lcd_rs),
    .lcd_data      (lcd_data),
    .cmd_valid     (cmd_valid),
    .cmd_byte      (cmd_byte),
    .pixel_valid   (pixel_valid),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .pixel_data    (pixel_data),
    .frame_done    (frame_done),
    .sleep_out     (sleep_out),
    .display_on    (display_on),
    .framing_error (framing_error)
  );

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Strobe counters seen on the DUT, compared with model totals at the end
  // to catch any stray pulse the per-byte checks would not look at.
  int seen_cmd = 0, seen_pix = 0, seen_fd = 0, seen_fe = 0;
  int exp_cmd = 0, exp_pix = 0, exp_fd = 0, exp_fe = 0;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) seen_cmd++;
    if (pixel_valid === 1'b1) seen_pix++;
    if (frame_done === 1'b1) seen_fd++;
    if (framing_error === 1'b1) seen_fe++;
  end

  // Reference model of the panel, one call per received byte.
  int  m_mode;
  int  m_xs, m_xe, m_ys, m_ye, m_x, m_y;
  bit  m_sleep, m_disp;
  int  params[$];
  int  hi_q[$];
  bit  e_cmd, e_pix, e_fd;
  int  e_cmdbyte, e_x, e_y, e_data;

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319;
    m_x = 0; m_y = 0;
    m_sleep = 0; m_disp = 0;
    params.delete();
    hi_q.delete();
  endfunction

  function automatic void model_byte(input bit dc, input int v);
    int s, e;
    e_cmd = 0; e_pix = 0; e_fd = 0;
    if (!dc) begin
      e_cmd = 1; e_cmdbyte = v; exp_cmd++;
      params.delete();
      hi_q.delete();
      m_mode = M_IDLE;
      case (v)
        'h2A: m_mode = M_CASET;
        'h2B: m_mode = M_RASET;
        'h2C: begin m_mode = M_RAMWR; m_x = m_xs; m_y = m_ys; end
        'h11: m_sleep = 1;
        'h10: m_sleep = 0;
        'h29: m_disp = 1;
        'h28: m_disp = 0;
        'h01: begin m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319; m_sleep = 0; m_disp = 0; end
        default: m_mode = M_SKIP;
      endcase
    end else if (m_mode == M_CASET || m_mode == M_RASET) begin
      params.push_back(v);
      if (params.size() == 4) begin
        s = (params[0] * 256 + params[1]) % (1 << COORD_W);
        e = (params[2] * 256 + params[3]) % (1 << COORD_W);
        if (m_mode == M_CASET) begin m_xs = s; m_xe = e; end
        else begin m_ys = s; m_ye = e; end
      end
    end else if (m_mode == M_RAMWR) begin
      if (hi_q.size() == 0) hi_q.push_back(v);
      else begin
        e_pix = 1; exp_pix++;
        e_data = hi_q.pop_front() * 256 + v;
        e_x = m_x; e_y = m_y;
        if (m_x >= m_xe) begin
          m_x = m_xs;
          if (m_y >= m_ye) begin m_y = m_ys; e_fd = 1; exp_fd++; end
          else m_y = m_y + 1;
        end else m_x = m_x + 1;
      end
    end
  endfunction

  task automatic check_all_zero(input string tag);
    checkOutput(tag, {cmd_valid, cmd_byte, pixel_valid, pixel_x, pixel_y, pixel_data,
                      frame_done, sleep_out, display_on, framing_error}, 64'd0);
  endtask

  // Shifts one byte MSB first, then checks the cycle after the final bit.
  task automatic applyStimulus(input bit dc, input logic [7:0] v, input bit keep_low);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      lcd_cs = 1'b0; lcd_rs = dc; lcd_data = v[i];
    end
    @(posedge clk); #1;
    model_byte(dc, int'(v));
    checkOutput("cmd_valid", cmd_valid, e_cmd);
    if (e_cmd) checkOutput("cmd_byte", cmd_byte, e_cmdbyte);
    checkOutput("sleep_out", sleep_out, m_sleep);
    checkOutput("display_on", display_on, m_disp);
    checkOutput("pixel_valid", pixel_valid, e_pix);
    checkOutput("frame_done", frame_done, e_fd);
    if (e_pix) begin
      checkOutput("pixel_x", pixel_x, e_x);
      checkOutput("pixel_y", pixel_y, e_y);
      checkOutput("pixel_data", pixel_data, e_data);
    end
    if (!keep_low) begin
      @(negedge clk);
      lcd_cs = 1'b1;
    end
  endtask

  task automatic send_partial(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      lcd_cs = 1'b0; lcd_rs = 1'b0; lcd_data = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    lcd_cs = 1'b1;
    @(posedge clk); #1;
    exp_fe++;
    checkOutput("framing_error", framing_error, 1);
    checkOutput("cmd_on_partial", cmd_valid, 0);
  endtask

  task automatic pulse_reset(input bit use_rst);
    @(negedge clk);
    if (use_rst) rst = 1'b1; else lcd_resetn = 1'b0;
    @(posedge clk); #1;
    check_all_zero(use_rst ? "rst_zero" : "resetn_zero");
    @(negedge clk);
    rst = 1'b0; lcd_resetn = 1'b1; lcd_cs = 1'b1;
    model_reset();
  endtask

  task automatic send_window(input int cmd, input int s, input int e);
    applyStimulus(1'b0, 8'(cmd), 1'b1);
    applyStimulus(1'b1, 8'(s >> 8), 1'b1);
    applyStimulus(1'b1, 8'(s), 1'b0);
    applyStimulus(1'b1, 8'(e >> 8), 1'b1);
    applyStimulus(1'b1, 8'(e), 1'b0);
  endtask

  task automatic send_pixel(input int px);
    applyStimulus(1'b1, 8'(px >> 8), 1'b1);
    applyStimulus(1'b1, 8'(px), 1'b0);
  endtask

  initial begin
    int op;
    int v;
    rst = 1'b1; lcd_resetn = 1'b1; lcd_cs = 1'b1; lcd_rs = 1'b0; lcd_data = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_zero");
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check_all_zero("idle_zero");

    applyStimulus(1'b0, 8'h11, 1'b0);
    applyStimulus(1'b0, 8'h29, 1'b0);
    applyStimulus(1'b0, 8'h28, 1'b0);

    send_window('h2A, 'h0028, 'h0117);
    send_window('h2B, 'h0035, 'h00B4);
    applyStimulus(1'b0, 8'h2C, 1'b0);
    repeat (3) send_pixel('h2FE0);
    checkOutput("first_px_col", 40, m_x - 3);

    send_window('h2A, 0, 1);
    send_window('h2B, 0, 1);
    applyStimulus(1'b0, 8'h2C, 1'b1);
    repeat (5) send_pixel('hF800);

    send_partial(5);
    applyStimulus(1'b0, 8'h2C, 1'b0);
    applyStimulus(1'b1, 8'hAB, 1'b0);
    applyStimulus(1'b0, 8'h2A, 1'b0);

    send_window('h2A, 'h0028, 'h0117);
    send_window('h2B, 'h0035, 'h00B4);
    applyStimulus(1'b0, 8'h2C, 1'b0);
    send_pixel('h1234);
    applyStimulus(1'b1, 8'h56, 1'b1);
    pulse_reset(1'b0);
    repeat (3) applyStimulus(1'b1, 8'h77, 1'b1);
    applyStimulus(1'b0, 8'h2C, 1'b0);
    send_pixel('h0F0F);

    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 99);
      if (op < 3) begin
        pulse_reset(1'($urandom_range(0, 1)));
      end else if (op < 6) begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          lcd_cs = 1'b0; lcd_data = 1'($urandom_range(0, 1));
        end
        pulse_reset(1'($urandom_range(0, 1)));
      end else if (op < 11) begin
        send_partial($urandom_range(1, 7));
      end else if (op < 35) begin
        case ($urandom_range(0, 9))
          0: v = 'h01; 1: v = 'h10; 2: v = 'h11; 3: v = 'h28; 4: v = 'h29;
          5: v = 'h2A; 6: v = 'h2B; 7, 8: v = 'h2C;
          default: v = $urandom_range(0, 255);
        endcase
        applyStimulus(1'b0, 8'(v), 1'($urandom_range(0, 1)));
      end else begin
        if ((m_mode == M_CASET || m_mode == M_RASET) && params.size() % 2 == 0)
          v = $urandom_range(0, 2);
        else if (m_mode == M_CASET || m_mode == M_RASET)
          v = $urandom_range(0, 6);
        else
          v = $urandom_range(0, 255);
        applyStimulus(1'b1, 8'(v), 1'($urandom_range(0, 1)));
      end
    end

    @(negedge clk);
    lcd_cs = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("cmd_count", seen_cmd, exp_cmd);
    checkOutput("pixel_count", seen_pix, exp_pix);
    checkOutput("frame_done_count", seen_fd, exp_fd);
    checkOutput("framing_error_count", seen_fe, exp_fe);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
